// File: rtl/multiciclo_memory_interface_if.sv
// Memory bus between the multicycle core's memory stage and an external
// variable-latency memory.
//   master : memory stage side - drives request, write enable, address and write data
//   slave  : memory side       - returns read data and a one-cycle completion strobe
interface multiciclo_memory_interface_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/multiciclo_memory_interface.sv
// Memory stage of the multicycle RISC-V core.
// Converts the control FSM's per-state strobes into one req/ack transaction on the memory bus,
// holds the Instruction Register and Memory Data Register, and stalls the control FSM while
// an access is outstanding.
// Ports:
//   clock, reset_n            core clock, asynchronous active-low reset
//   ReadMemory, WriteMemory   access strobes from the control FSM
//   WriteInstructionRegister  read data goes to IR instead of MDR
//   MemoryAddressOrigin       0: address from pc, 1: from alu_result
//   pc, alu_result            address sources
//   store_data                write data for stores
//   stall                     control FSM must hold its state while high
//   instruction, memory_data  IR and MDR contents
//   bus_error                 sticky: some transaction timed out
//   bus                       memory bus (master side)
module multiciclo_memory_interface #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          ReadMemory,
  input  logic                          WriteMemory,
  input  logic                          WriteInstructionRegister,
  input  logic                          MemoryAddressOrigin,
  input  logic [ADDR_WIDTH-1:0]         pc,
  input  logic [ADDR_WIDTH-1:0]         alu_result,
  input  logic [DATA_WIDTH-1:0]         store_data,
  output logic                          stall,
  output logic [DATA_WIDTH-1:0]         instruction,
  output logic [DATA_WIDTH-1:0]         memory_data,
  output logic                          bus_error,
  multiciclo_memory_interface_if.master bus
);

  // Counter value on the last BUSY edge before the abort is taken, so that exactly
  // TIMEOUT BUSY cycles elapse without an ack.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  ir_sel_q, ir_sel_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
  logic                  err_q, err_d;
  logic [7:0]            cnt_q, cnt_d;

  logic access_req;
  assign access_req = ReadMemory | WriteMemory;

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ir_sel_d = ir_sel_q;
    ir_d     = ir_q;
    mdr_d    = mdr_q;
    err_d    = err_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (access_req) begin
          addr_d   = MemoryAddressOrigin ? alu_result : pc;
          wdata_d  = store_data;
          // A write always wins over a simultaneous read.
          we_d     = WriteMemory;
          ir_sel_d = WriteInstructionRegister & ~WriteMemory;
          cnt_d    = '0;
          req_d    = 1'b1;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        if (bus.mem_ack) begin
          if (!we_q) begin
            if (ir_sel_q) ir_d = bus.mem_rdata;
            else          mdr_d = bus.mem_rdata;
          end
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = StDone;
        end else if (cnt_q >= TimeoutLast) begin
          err_d   = 1'b1;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = StDone;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        // Single release cycle; strobes still high here must not start a new access.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ir_sel_q <= 1'b0;
      ir_q     <= '0;
      mdr_q    <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ir_sel_q <= ir_sel_d;
      ir_q     <= ir_d;
      mdr_q    <= mdr_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Stall is raised combinationally in IDLE so the control FSM holds on the launch edge.
  always_comb begin
    stall = 1'b0;
    unique case (state_q)
      StIdle:  stall = access_req;
      StBusy:  stall = 1'b1;
      StDone:  stall = 1'b0;
      default: stall = 1'b0;
    endcase
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign instruction   = ir_q;
  assign memory_data   = mdr_q;
  assign bus_error     = err_q;

endmodule

// File: tb/tb_multiciclo_memory_interface.sv
module tb_multiciclo_memory_interface;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rd_m = 1'b0, wr_m = 1'b0, wir = 1'b0, org = 1'b0;
  logic [31:0] pc_v = '0, alu_v = '0, sd_v = '0, rdata_v = '0;
  logic        ack_a = 1'b0, ack_b = 1'b0;
  logic        stall_a, stall_b, berr_a, berr_b;
  logic [31:0] instr_a, instr_b, mdr_a, mdr_b;

  int total = 0;
  int bad = 0;

  logic [31:0] m_ir, m_mdr;
  logic        m_err;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic        err;
    int          stalls;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  multiciclo_memory_interface_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if_a ();
  multiciclo_memory_interface_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if_b ();
  assign if_a.mem_ack   = ack_a;
  assign if_a.mem_rdata = rdata_v;
  assign if_b.mem_ack   = ack_b;
  assign if_b.mem_rdata = rdata_v;

  multiciclo_memory_interface #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(255)) dut (
    .clock(clk), .reset_n(reset_n), .ReadMemory(rd_m), .WriteMemory(wr_m),
    .WriteInstructionRegister(wir), .MemoryAddressOrigin(org), .pc(pc_v),
    .alu_result(alu_v), .store_data(sd_v), .stall(stall_a), .instruction(instr_a),
    .memory_data(mdr_a), .bus_error(berr_a), .bus(if_a)
  );

  multiciclo_memory_interface #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut_to (
    .clock(clk), .reset_n(reset_n), .ReadMemory(rd_m), .WriteMemory(wr_m),
    .WriteInstructionRegister(wir), .MemoryAddressOrigin(org), .pc(pc_v),
    .alu_result(alu_v), .store_data(sd_v), .stall(stall_b), .instruction(instr_b),
    .memory_data(mdr_b), .bus_error(berr_b), .bus(if_b)
  );

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    rd_m = 0; wr_m = 0; wir = 0; org = 0; ack_a = 0; ack_b = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_ir = '0; m_mdr = '0; m_err = 1'b0;
  endtask

  // Runs one access on DUT sel (0: TIMEOUT=255, 1: TIMEOUT=4). ack_after = BUSY cycle in which
  // ack is raised (0 = never). Inputs are scrambled during BUSY; strobes stay high through DONE.
  task automatic drive_access(input bit sel, input logic rd, wr, wr_ir, origin,
                              input logic [31:0] pcv, aluv, sdv, rdv, input int ack_after,
                              output int stalls, output int busy_n,
                              output logic [31:0] addr_s, wdata_s, output logic we_s,
                              output bit stable, output bit done_ok,
                              output logic stall_done, we_done, relaunch,
                              output logic [31:0] ir_s, mdr_s, output logic err_s);
    stalls = 0; busy_n = 0; stable = 1; done_ok = 0;
    addr_s = 'x; wdata_s = 'x; we_s = 'x; stall_done = 'x; we_done = 'x; relaunch = 'x;
    ir_s = 'x; mdr_s = 'x; err_s = 'x;
    @(negedge clk);
    rd_m = rd; wr_m = wr; wir = wr_ir; org = origin;
    pc_v = pcv; alu_v = aluv; sd_v = sdv; rdata_v = rdv; ack_a = 0; ack_b = 0;
    #1;
    if ((sel ? stall_b : stall_a) === 1'b1) stalls++;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if ((sel ? if_b.mem_req : if_a.mem_req) === 1'b1) begin
        busy_n++;
        if ((sel ? stall_b : stall_a) === 1'b1) stalls++;
        if (busy_n == 1) begin
          addr_s  = sel ? if_b.mem_addr : if_a.mem_addr;
          wdata_s = sel ? if_b.mem_wdata : if_a.mem_wdata;
          we_s    = sel ? if_b.mem_we : if_a.mem_we;
        end else if (addr_s !== (sel ? if_b.mem_addr : if_a.mem_addr) ||
                     wdata_s !== (sel ? if_b.mem_wdata : if_a.mem_wdata) ||
                     we_s !== (sel ? if_b.mem_we : if_a.mem_we)) begin
          stable = 0;
        end
        if (sel) ack_b = (busy_n == ack_after);
        else     ack_a = (busy_n == ack_after);
        pc_v = ~pcv; alu_v = ~aluv; sd_v = ~sdv; org = ~origin;
      end else begin
        done_ok    = 1;
        ack_a = 0; ack_b = 0;
        stall_done = sel ? stall_b : stall_a;
        we_done    = sel ? if_b.mem_we : if_a.mem_we;
        ir_s       = sel ? instr_b : instr_a;
        mdr_s      = sel ? mdr_b : mdr_a;
        err_s      = sel ? berr_b : berr_a;
        @(negedge clk);
        relaunch = sel ? if_b.mem_req : if_a.mem_req;
        rd_m = 0; wr_m = 0; wir = 0; org = 0;
        break;
      end
    end
  endtask

  // Pushes expectation, runs the access, pops and compares against the DUT's observed values.
  task automatic run_and_check(input string nm, input bit sel, input logic rd, wr, wr_ir,
                               origin, input logic [31:0] pcv, aluv, sdv, rdv,
                               input int ack_after, output int busy_n);
    exp_t e, g;
    int stalls;
    logic [31:0] addr_s, wdata_s, ir_s, mdr_s;
    logic we_s, stall_done, we_done, relaunch, err_s;
    bit stable, done_ok;
    e.addr = origin ? aluv : pcv;
    e.we = wr;
    e.wdata = sdv;
    if (ack_after == 0) m_err = 1'b1;
    else if (!wr && wr_ir) m_ir = rdv;
    else if (!wr) m_mdr = rdv;
    e.ir = m_ir; e.mdr = m_mdr; e.err = m_err;
    e.stalls = (ack_after == 0) ? (sel ? 5 : 256) : ack_after + 1;
    exp_q.push_back(e);
    drive_access(sel, rd, wr, wr_ir, origin, pcv, aluv, sdv, rdv, ack_after, stalls, busy_n,
                 addr_s, wdata_s, we_s, stable, done_ok, stall_done, we_done, relaunch,
                 ir_s, mdr_s, err_s);
    g = exp_q.pop_front();
    total++;
    if (!done_ok) begin
      bad++; $display("FAIL %s_done got=no_done exp=done", nm);
    end
    total++;
    if (addr_s !== g.addr) begin bad++; $display("FAIL %s_addr got=%h exp=%h", nm, addr_s, g.addr); end
    total++;
    if (we_s !== g.we) begin bad++; $display("FAIL %s_we got=%b exp=%b", nm, we_s, g.we); end
    total++;
    if (wdata_s !== g.wdata) begin bad++; $display("FAIL %s_wdata got=%h exp=%h", nm, wdata_s, g.wdata); end
    total++;
    if (!stable) begin bad++; $display("FAIL %s_stable got=changed exp=held", nm); end
    total++;
    if (stalls !== g.stalls) begin bad++; $display("FAIL %s_stalls got=%0d exp=%0d", nm, stalls, g.stalls); end
    total++;
    if (ir_s !== g.ir) begin bad++; $display("FAIL %s_ir got=%h exp=%h", nm, ir_s, g.ir); end
    total++;
    if (mdr_s !== g.mdr) begin bad++; $display("FAIL %s_mdr got=%h exp=%h", nm, mdr_s, g.mdr); end
    total++;
    if (err_s !== g.err) begin bad++; $display("FAIL %s_err got=%b exp=%b", nm, err_s, g.err); end
    total++;
    if (stall_done !== 1'b0 || we_done !== 1'b0 || relaunch !== 1'b0) begin
      bad++;
      $display("FAIL %s_done_cycle got=stall%b/we%b/relaunch%b exp=0/0/0", nm, stall_done,
               we_done, relaunch);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++;
    if ({stall_a, if_a.mem_req, if_a.mem_we, berr_a} !== 4'b0) begin
      bad++; $display("FAIL reset_ctl got=%b exp=0000", {stall_a, if_a.mem_req, if_a.mem_we, berr_a});
    end
    total++;
    if (if_a.mem_addr !== 32'h0 || if_a.mem_wdata !== 32'h0) begin
      bad++; $display("FAIL reset_bus got=%h/%h exp=0/0", if_a.mem_addr, if_a.mem_wdata);
    end
    total++;
    if (instr_a !== 32'h0 || mdr_a !== 32'h0) begin
      bad++; $display("FAIL reset_regs got=%h/%h exp=0/0", instr_a, mdr_a);
    end
    do_reset();
  endtask

  task automatic test_fetch();
    int b;
    do_reset();
    run_and_check("fetch", 0, 1, 0, 1, 0, 32'h40, 32'h999, 32'h5555, 32'h00A00093, 1, b);
  endtask

  task automatic test_load();
    int b;
    run_and_check("load", 0, 1, 0, 0, 1, 32'h44, 32'h100, 32'h0, 32'hDEADBEEF, 5, b);
  endtask

  task automatic test_store();
    int b;
    run_and_check("store", 0, 0, 1, 0, 1, 32'h48, 32'h200, 32'h12345678, 32'hCAFEF00D, 3, b);
  endtask

  task automatic test_back_to_back();
    int b;
    run_and_check("b2b_0", 0, 1, 0, 1, 0, 32'h4, 32'h0, 32'h0, 32'h00000013, 1, b);
    run_and_check("b2b_1", 0, 1, 0, 0, 1, 32'h8, 32'h300, 32'h0, 32'h0BADF00D, 2, b);
    run_and_check("b2b_2", 0, 1, 0, 1, 0, 32'hC, 32'h0, 32'h0, 32'h00100093, 4, b);
  endtask

  task automatic test_timeout();
    int b;
    do_reset();
    run_and_check("tmo", 1, 1, 0, 0, 1, 32'h0, 32'h400, 32'h0, 32'h55AA55AA, 0, b);
    total++;
    if (b !== 4) begin bad++; $display("FAIL tmo_busy_cycles got=%0d exp=4", b); end
    run_and_check("tmo_good_ld", 1, 1, 0, 0, 1, 32'h0, 32'h404, 32'h0, 32'h11112222, 2, b);
    run_and_check("tmo_good_if", 1, 1, 0, 1, 0, 32'h20, 32'h0, 32'h0, 32'h33334444, 3, b);
    run_and_check("tmo_edge", 1, 1, 0, 0, 0, 32'h24, 32'h0, 32'h0, 32'h66667777, 4, b);
  endtask

  task automatic test_reset_busy();
    int b;
    do_reset();
    run_and_check("rb_fetch", 0, 1, 0, 1, 0, 32'h10, 32'h0, 32'h0, 32'hAAAA0001, 1, b);
    run_and_check("rb_load", 0, 1, 0, 0, 1, 32'h10, 32'h500, 32'h0, 32'hBBBB0002, 1, b);
    @(negedge clk);
    rd_m = 1; wir = 0; org = 1; alu_v = 32'h600; rdata_v = 32'h77;
    @(negedge clk);
    total++;
    if (if_a.mem_req !== 1'b1) begin bad++; $display("FAIL rb_launch got=%b exp=1", if_a.mem_req); end
    #2;
    reset_n = 1'b0;
    rd_m = 0; wir = 0; org = 0;
    #1;
    total++;
    if (if_a.mem_req !== 1'b0 || stall_a !== 1'b0) begin
      bad++; $display("FAIL rb_async got=req%b/stall%b exp=0/0", if_a.mem_req, stall_a);
    end
    total++;
    if (instr_a !== 32'h0 || mdr_a !== 32'h0) begin
      bad++; $display("FAIL rb_regs got=%h/%h exp=0/0", instr_a, mdr_a);
    end
    @(negedge clk);
    ack_a = 1'b1;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (if_a.mem_req !== 1'b0 || instr_a !== 32'h0 || mdr_a !== 32'h0 || stall_a !== 1'b0) begin
      bad++;
      $display("FAIL rb_late_ack got=req%b/%h/%h/stall%b exp=0/0/0/0", if_a.mem_req, instr_a,
               mdr_a, stall_a);
    end
    ack_a = 1'b0;
  endtask

  task automatic test_both_and_stray();
    int b;
    do_reset();
    @(negedge clk);
    rdata_v = 32'hBAD0BAD0;
    ack_a = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (instr_a !== 32'h0 || mdr_a !== 32'h0 || if_a.mem_req !== 1'b0) begin
      bad++; $display("FAIL stray_ack got=%h/%h/req%b exp=0/0/0", instr_a, mdr_a, if_a.mem_req);
    end
    ack_a = 1'b0;
    run_and_check("both", 0, 1, 1, 1, 0, 32'h80, 32'h0, 32'hA5A5A5A5, 32'hFFFF0000, 2, b);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_ir = '0; m_mdr = '0; m_err = 1'b0;
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_back_to_back();
    test_timeout();
    test_reset_busy();
    test_both_and_stray();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
